// File: rtl/bus_wr_fifo_pkg.sv
// Register map and STATUS/CTRL layout shared by the bus-writable FIFO and its bench.
package bus_wr_fifo_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_e;

  localparam int ST_OVF_BIT       = 15;
  localparam int ST_FULL_BIT      = 14;
  localparam int ST_EMPTY_BIT     = 13;
  localparam int ST_CNT_W         = 13;
  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;

  function automatic logic [15:0] status_word(input logic ovf, input logic full,
                                              input logic empty, input logic [ST_CNT_W-1:0] cnt);
    logic [15:0] w;
    w                 = '0;
    w[ST_CNT_W-1:0]   = cnt;
    w[ST_EMPTY_BIT]   = empty;
    w[ST_FULL_BIT]    = full;
    w[ST_OVF_BIT]     = ovf;
    return w;
  endfunction

endpackage

// File: rtl/bus_wr_fifo_if.sv
// Bus register port plus the valid/ready drain stream of the bus-writable FIFO.
interface bus_wr_fifo_if;
    logic        i_Bus_CS;
    logic        i_Bus_Wr_Rd_n;
    logic [15:0] i_Bus_Addr8;
    logic [15:0] i_Bus_Wr_Data;
    logic [15:0] o_Bus_Rd_Data;
    logic        o_Bus_Rd_DV;
    logic [15:0] o_Rd_Data;
    logic        o_Rd_DV;
    logic        i_Rd_Ready;

    modport slave (
        input  i_Bus_CS, i_Bus_Wr_Rd_n, i_Bus_Addr8, i_Bus_Wr_Data, i_Rd_Ready,
        output o_Bus_Rd_Data, o_Bus_Rd_DV, o_Rd_Data, o_Rd_DV
    );

    modport master (
        output i_Bus_CS, i_Bus_Wr_Rd_n, i_Bus_Addr8, i_Bus_Wr_Data, i_Rd_Ready,
        input  o_Bus_Rd_Data, o_Bus_Rd_DV, o_Rd_Data, o_Rd_DV
    );
endinterface

// File: rtl/bus_wr_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port on a single clock.
module bus_wr_fifo_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Read data only updates on rd_en, so an unconsumed word stays parked here.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bus_wr_fifo.sv
// Bus-writable FIFO: CPU pushes words through a DATA register, fabric drains via valid/ready.
module bus_wr_fifo
    import bus_wr_fifo_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic          i_Bus_Clk,
    input  logic          i_Bus_Rst_L,
    bus_wr_fifo_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d, unread;
    logic             out_vld_q, out_vld_d, ram_vld_q, ram_vld_d, ovf_q, ovf_d;
    logic [15:0]      out_data_q, out_data_d, ram_rdata;
    logic             bus_dv_q, bus_dv_d;
    logic [15:0]      bus_data_q, bus_data_d;

    logic     wr_stb, rd_stb, push_req, push_ok, flush, clr_ovf, full, pop, load_out, rd_en;
    reg_sel_e sel;
    logic     unused_addr;

    assign wr_stb   = bus.i_Bus_CS &  bus.i_Bus_Wr_Rd_n;
    assign rd_stb   = bus.i_Bus_CS & ~bus.i_Bus_Wr_Rd_n;
    assign sel      = reg_sel_e'(bus.i_Bus_Addr8[2:1]);
    assign unused_addr = ^{bus.i_Bus_Addr8[15:3], bus.i_Bus_Addr8[0]};

    assign push_req = wr_stb && (sel == REG_DATA);
    assign flush    = wr_stb && (sel == REG_CTRL) && bus.i_Bus_Wr_Data[CTRL_FLUSH_BIT];
    assign clr_ovf  = wr_stb && (sel == REG_CTRL) && bus.i_Bus_Wr_Data[CTRL_CLR_OVF_BIT];
    assign full     = (count_q == CNT_W'(DEPTH));
    assign push_ok  = push_req && !full && !flush;
    assign pop      = out_vld_q && bus.i_Rd_Ready;

    // Two-stage prefetch: the RAM read register holds the next word so a pop can refill
    // the output register on the same edge, giving one word per cycle.
    assign unread   = count_q - CNT_W'(out_vld_q) - CNT_W'(ram_vld_q);
    assign load_out = ram_vld_q && (!out_vld_q || pop);
    assign rd_en    = (unread != '0) && (!ram_vld_q || load_out);

    bus_wr_fifo_ram #(.WIDTH(16), .DEPTH(DEPTH)) u_ram (
        .clk_i     (i_Bus_Clk),
        .wr_en_i   (push_ok),
        .wr_addr_i (wptr_q),
        .wr_data_i (bus.i_Bus_Wr_Data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rptr_q),
        .rd_data_o (ram_rdata)
    );

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        ram_vld_d  = rd_en || (ram_vld_q && !load_out);
        ovf_d      = ovf_q;

        if (push_ok) wptr_d = wptr_q + PTR_W'(1);
        if (rd_en)   rptr_d = rptr_q + PTR_W'(1);

        if (load_out) begin
            out_vld_d  = 1'b1;
            out_data_d = ram_rdata;
        end else if (pop) begin
            out_vld_d  = 1'b0;
        end

        if (push_req && full) ovf_d = 1'b1;
        else if (clr_ovf)     ovf_d = 1'b0;

        if (flush) begin
            wptr_d    = '0;
            rptr_d    = '0;
            count_d   = '0;
            out_vld_d = 1'b0;
            ram_vld_d = 1'b0;
        end

        // STATUS is captured from next-state so it includes the strobe edge itself.
        bus_dv_d   = rd_stb;
        bus_data_d = '0;
        if (rd_stb && (sel == REG_STATUS))
            bus_data_d = status_word(ovf_d, count_d == CNT_W'(DEPTH), count_d == '0,
                                     ST_CNT_W'(count_d));
    end

    always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
        if (!i_Bus_Rst_L) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            ram_vld_q  <= 1'b0;
            ovf_q      <= 1'b0;
            bus_dv_q   <= 1'b0;
            bus_data_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            ram_vld_q  <= ram_vld_d;
            ovf_q      <= ovf_d;
            bus_dv_q   <= bus_dv_d;
            bus_data_q <= bus_data_d;
        end
    end

    assign bus.o_Rd_DV       = out_vld_q;
    assign bus.o_Rd_Data     = out_data_q;
    assign bus.o_Bus_Rd_DV   = bus_dv_q;
    assign bus.o_Bus_Rd_Data = bus_data_q;

endmodule
